// File: rtl/audio_pkg.sv
// ============================================================================
// Module      : audio_pkg
// Description : Shared audio constants, stereo sample type and slot helper
//               for the I2S transmit path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package audio_pkg;

   localparam int c_bit_w    = 24;
   localparam int c_slot     = 32;
   localparam int c_bclk_div = 4;

   typedef struct packed {
      logic signed [c_bit_w-1:0] l;
      logic signed [c_bit_w-1:0] r;
   } stereo_t;

   // Bit index (MSB first) for a position inside a slot, or -1 when idle.
   function automatic int msb_index(input int pos, input int bits);
      return (pos >= 0 && pos < bits) ? bits - 1 - pos : -1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/i2s_tx_if.sv
// ============================================================================
// Module      : i2s_tx_if
// Description : Stereo sample handshake between the mixer and the I2S
//               transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface i2s_tx_if import audio_pkg::*; #(
   parameter int BIT = c_bit_w
);
   logic signed [BIT-1:0] in_L;
   logic signed [BIT-1:0] in_R;
   logic                  in_valid;
   logic                  in_ready;

   modport master (output in_L, output in_R, output in_valid, input in_ready);
   modport slave  (input in_L, input in_R, input in_valid, output in_ready);
endinterface

`default_nettype wire

// File: rtl/i2s_clkgen.sv
// ============================================================================
// Module      : i2s_clkgen
// Description : BCLK divider and bit counter; produces BCLK, LRCK and the
//               falling-edge / frame-boundary strobes. I2S_TX_LJ_EN selects
//               left-justified LRCK polarity.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_clkgen import audio_pkg::*; #(
   parameter int SLOT     = c_slot,
   parameter int BCLK_DIV = c_bclk_div,
   localparam int DW      = $clog2(BCLK_DIV),
   localparam int BW      = $clog2(2 * SLOT)
) (
   input  wire logic          CLK,
   input  wire logic          RST,
   output logic               BCLK,
   output logic               LRCK,
   output logic               frame_start,
   output logic               fall,
   output logic               boundary,
   output logic [BW-1:0]      bit_cnt_nxt
);

`ifdef I2S_TX_LJ_EN
   localparam logic c_lrck_left = 1'b1;
`else
   localparam logic c_lrck_left = 1'b0;
`endif

   logic [DW-1:0] r_div_cnt;
   logic [BW-1:0] r_bit_cnt;
   logic [DW-1:0] w_div_nxt;

   assign fall        = (r_div_cnt == DW'(BCLK_DIV - 1));
   assign boundary    = fall && (r_bit_cnt == BW'(2 * SLOT - 1));
   assign w_div_nxt   = fall ? '0 : r_div_cnt + DW'(1);
   assign bit_cnt_nxt = boundary ? '0 : (fall ? r_bit_cnt + BW'(1) : r_bit_cnt);

   // BCLK follows the divider value it will hold, so it is aligned with div_cnt.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_div_cnt   <= '0;
         r_bit_cnt   <= '0;
         BCLK        <= 1'b0;
         LRCK        <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         r_div_cnt   <= w_div_nxt;
         r_bit_cnt   <= bit_cnt_nxt;
         BCLK        <= (w_div_nxt >= DW'(BCLK_DIV / 2));
         frame_start <= boundary;
         if (fall) begin
            LRCK <= (bit_cnt_nxt >= BW'(SLOT)) ? ~c_lrck_left : c_lrck_left;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/i2s_tx.sv
// ============================================================================
// Module      : i2s_tx
// Description : Stereo I2S transmitter with one-entry holding register and
//               underrun repeat. I2S_TX_LJ_EN selects left-justified format.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_tx import audio_pkg::*; #(
   parameter int BIT      = c_bit_w,
   parameter int SLOT     = c_slot,
   parameter int BCLK_DIV = c_bclk_div
) (
   input  wire logic CLK,
   input  wire logic RST,
   i2s_tx_if.slave   bus,
   output logic      BCLK,
   output logic      LRCK,
   output logic      SDATA,
   output logic      frame_start,
   output logic      underrun
);

   localparam int BW = $clog2(2 * SLOT);
   localparam int IW = $clog2(BIT);

`ifdef I2S_TX_LJ_EN
   localparam int c_delay = 0;
`else
   localparam int c_delay = 1;
`endif

   if (SLOT < BIT + 1) begin : g_chk_slot
      $error("i2s_tx: SLOT must be at least BIT+1");
   end
   if (BCLK_DIV < 2 || (BCLK_DIV % 2) != 0) begin : g_chk_div
      $error("i2s_tx: BCLK_DIV must be even and at least 2");
   end

   logic          w_fall;
   logic          w_boundary;
   logic [BW-1:0] w_bit_nxt;

   i2s_clkgen #(
      .SLOT     (SLOT),
      .BCLK_DIV (BCLK_DIV)
   ) u_clkgen (
      .CLK         (CLK),
      .RST         (RST),
      .BCLK        (BCLK),
      .LRCK        (LRCK),
      .frame_start (frame_start),
      .fall        (w_fall),
      .boundary    (w_boundary),
      .bit_cnt_nxt (w_bit_nxt)
   );

   logic           r_ready;
   logic           r_hold_full;
   logic [BIT-1:0] r_hold_l, r_hold_r;
   logic [BIT-1:0] r_last_l, r_last_r;
   logic [BIT-1:0] r_shift_l, r_shift_r;
   logic           r_sdata;
   logic           r_underrun;

   logic           w_xfer;
   logic           w_hold_full_nxt;
   logic [BIT-1:0] w_next_l, w_next_r;
   logic [BIT-1:0] w_word;
   int             w_pos;
   int             w_idx;
   logic           w_sdata_nxt;

   assign w_xfer          = bus.in_valid & r_ready;
   assign w_hold_full_nxt = (r_hold_full & ~w_boundary) | w_xfer;

   // The sample that will be on the wire after this edge; at a boundary the
   // shift registers are being reloaded, so look through to their new value.
   assign w_next_l = w_boundary ? (r_hold_full ? r_hold_l : r_last_l) : r_shift_l;
   assign w_next_r = w_boundary ? (r_hold_full ? r_hold_r : r_last_r) : r_shift_r;

   always_comb begin
      w_pos       = int'(w_bit_nxt);
      w_word      = w_next_l;
      w_idx       = -1;
      w_sdata_nxt = 1'b0;
      if (w_pos < SLOT) begin
         w_idx = msb_index(w_pos - c_delay, BIT);
      end else begin
         w_word = w_next_r;
         w_idx  = msb_index(w_pos - SLOT - c_delay, BIT);
      end
      if (w_idx >= 0) begin
         w_sdata_nxt = w_word[IW'(w_idx)];
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_ready     <= 1'b1;
         r_hold_full <= 1'b0;
         r_hold_l    <= '0;
         r_hold_r    <= '0;
         r_last_l    <= '0;
         r_last_r    <= '0;
         r_shift_l   <= '0;
         r_shift_r   <= '0;
         r_sdata     <= 1'b0;
         r_underrun  <= 1'b0;
      end else begin
         r_hold_full <= w_hold_full_nxt;
         r_ready     <= ~w_hold_full_nxt;
         r_underrun  <= w_boundary & ~r_hold_full;
         if (w_xfer) begin
            r_hold_l <= bus.in_L;
            r_hold_r <= bus.in_R;
         end
         if (w_boundary) begin
            r_shift_l <= w_next_l;
            r_shift_r <= w_next_r;
            if (r_hold_full) begin
               r_last_l <= r_hold_l;
               r_last_r <= r_hold_r;
            end
         end
         if (w_fall) begin
            r_sdata <= w_sdata_nxt;
         end
      end
   end

   assign bus.in_ready = r_ready;
   assign SDATA        = r_sdata;
   assign underrun     = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_i2s_tx.sv
// ============================================================================
// Module      : tb_i2s_tx
// Description : Randomized self-checking bench for i2s_tx against a
//               frame-level reference model (honours I2S_TX_LJ_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2s_tx;
   import audio_pkg::*;

   localparam int BIT   = c_bit_w;
   localparam int SLOT  = c_slot;
   localparam int DIV   = c_bclk_div;
   localparam int FRAME = 2 * SLOT * DIV;
`ifdef I2S_TX_LJ_EN
   localparam int   D  = 0;
   localparam logic LJ = 1'b1;
`else
   localparam int   D  = 1;
   localparam logic LJ = 1'b0;
`endif

   logic CLK;
   logic RST;
   logic BCLK, LRCK, SDATA, frame_start, underrun;

   i2s_tx_if #(.BIT(BIT)) bus ();

   i2s_tx #(
      .BIT      (BIT),
      .SLOT     (SLOT),
      .BCLK_DIV (DIV)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .bus         (bus),
      .BCLK        (BCLK),
      .LRCK        (LRCK),
      .SDATA       (SDATA),
      .frame_start (frame_start),
      .underrun    (underrun)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_chk, n_fail;
   int t;                       // CLK edges since reset release
   int c_xfer, c_ur, c_rdy;
   stereo_t m_cur, m_last, m_hold;
   logic m_hold_full, m_fs, m_ur;
   logic [BIT-1:0] cap_l, cap_r;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0] outs();
      return {BCLK, LRCK, SDATA, frame_start, underrun, bus.in_ready};
   endfunction

   // Expected pins derived from the elapsed cycle count and current frame pair.
   function automatic logic [5:0] exp_outs();
      int div, b, pos;
      logic [BIT-1:0] ch;
      logic bclk, lrck, sd;
      div  = t % DIV;
      b    = (t / DIV) % (2 * SLOT);
      bclk = (div >= DIV / 2);
      lrck = (t < DIV) ? 1'b0 : ((b >= SLOT) ^ LJ);
      ch   = (b < SLOT) ? m_cur.l : m_cur.r;
      pos  = (b % SLOT) - D;
      sd   = (pos >= 0 && pos < BIT) ? ch[BIT-1-pos] : 1'b0;
      return {bclk, lrck, sd, m_fs, m_ur, ~m_hold_full};
   endfunction

   task automatic reset_model();
      t = 0;
      m_cur = '0; m_last = '0; m_hold = '0;
      m_hold_full = 1'b0; m_fs = 1'b0; m_ur = 1'b0;
      cap_l = '0; cap_r = '0;
   endtask

   task automatic step();
      logic xfer;
      int b;
      if (bus.in_valid && bus.in_ready) c_xfer++;
      @(posedge CLK);
      xfer = bus.in_valid && !m_hold_full;
      t++;
      m_fs = (t % FRAME == 0);
      m_ur = 1'b0;
      if (m_fs) begin
         if (m_hold_full) begin
            m_cur = m_hold; m_last = m_hold; m_hold_full = 1'b0;
         end else begin
            m_cur = m_last; m_ur = 1'b1;
         end
      end
      if (xfer) begin
         m_hold.l = bus.in_L; m_hold.r = bus.in_R; m_hold_full = 1'b1;
      end
      @(negedge CLK);
      chk($sformatf("outs t=%0d", t), outs(), exp_outs());
      if (underrun) c_ur++;
      if (bus.in_ready) c_rdy++;
      if (t % DIV == DIV / 2) begin
         b = (t / DIV) % (2 * SLOT);
         if (b >= D && b < D + BIT) cap_l = {cap_l[BIT-2:0], SDATA};
         if (b >= SLOT + D && b < SLOT + D + BIT) cap_r = {cap_r[BIT-2:0], SDATA};
      end
   endtask

   task automatic cyc(input logic v, input logic [BIT-1:0] l, input logic [BIT-1:0] r);
      bus.in_valid = v; bus.in_L = l; bus.in_R = r;
      step();
   endtask

   function automatic logic [BIT-1:0] rnd();
      return BIT'($urandom);
   endfunction

   task automatic do_reset(input string tag);
      bus.in_valid = 1'b0;
      RST = 1'b1;
      #1;
      chk({tag, "_async"}, outs(), 6'b000001);
      repeat (2) @(negedge CLK);
      chk({tag, "_held"}, outs(), 6'b000001);
      RST = 1'b0;
      reset_model();
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      c_xfer = 0; c_ur = 0; c_rdy = 0;
      RST = 1'b0;
      bus.in_valid = 1'b0; bus.in_L = '0; bus.in_R = '0;
      reset_model();
      @(negedge CLK);
      do_reset("reset");

      // Idle first frame: zeros, then underrun at the first boundary
      while (t < FRAME) cyc(1'b0, rnd(), rnd());
      chk("p1_frame_start", frame_start, 1'b1);
      chk("p1_underrun", underrun, 1'b1);
      chk("p1_zero_l", cap_l, '0);
      repeat (40) cyc(1'b0, rnd(), rnd());

      // Directed pair loaded during frame 0
      do_reset("p2_rst");
      repeat (10) cyc(1'b0, rnd(), rnd());
      cyc(1'b1, 24'h800001, 24'h7FFFFE);
      while (t < FRAME) cyc(1'b0, rnd(), rnd());
      chk("p2_no_underrun", underrun, 1'b0);
      while (t < 2 * FRAME) cyc(1'b0, rnd(), rnd());
      chk("p2_left_word", cap_l, 24'h800001);
      chk("p2_right_word", cap_r, 24'h7FFFFE);

      // Continuous valid: one transfer per frame, ready high one cycle per frame
      repeat (10) cyc(1'b1, rnd(), rnd());
      while (t % FRAME != 0) cyc(1'b1, rnd(), rnd());
      c_xfer = 0; c_ur = 0; c_rdy = 0;
      repeat (3 * FRAME) cyc(1'b1, rnd(), rnd());
      chk("p3_transfers", c_xfer, 3);
      chk("p3_underruns", c_ur, 0);
      chk("p3_ready_cycles", c_rdy, 3);

      // Starved source: repeat last pair with an underrun per boundary
      for (int i = 0; i < 2 * FRAME && m_hold_full; i++) cyc(1'b0, rnd(), rnd());
      chk("p4_ready", bus.in_ready, 1'b1);
      cyc(1'b1, 24'h123456, 24'h654321);
      do cyc(1'b0, rnd(), rnd()); while (t % FRAME != 0);
      c_ur = 0;
      repeat (2 * FRAME) cyc(1'b0, rnd(), rnd());
      chk("p4_underruns", c_ur, 2);
      chk("p4_repeat_l", cap_l, 24'h123456);
      chk("p4_repeat_r", cap_r, 24'h654321);

      // Random traffic
      repeat (4 * FRAME) cyc(($urandom_range(0, 5) == 0), rnd(), rnd());

      // Reset at bit_cnt 10 with a pair pending
      for (int i = 0; i < 2 * FRAME && m_hold_full; i++) cyc(1'b0, rnd(), rnd());
      cyc(1'b1, 24'hABCDEF, 24'h123ABC);
      while (t % FRAME != 10 * DIV) cyc(1'b0, rnd(), rnd());
      do_reset("p6_rst");
      while (t < FRAME) cyc(1'b0, rnd(), rnd());
      chk("p6_zero_l", cap_l, '0);
      chk("p6_zero_r", cap_r, '0);
      chk("p6_underrun", underrun, 1'b1);
      repeat (FRAME) cyc(1'b0, rnd(), rnd());
      chk("p6_repeat_zero", cap_l, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
